// File: rtl/qam16_symbol_upsampler_if.sv
// Bus bundle for the 16-QAM symbol upsampler.
// Serial bit input handshake, sample pacing and I/Q impulse outputs.
interface qam16_symbol_upsampler_if #(
    parameter int BIT_OUT = 14
) ();
    logic                      BIT_IN;
    logic                      BIT_VALID;
    logic                      BIT_READY;
    logic                      SAMPLE_EN;
    logic signed [BIT_OUT-1:0] I_OUT;
    logic signed [BIT_OUT-1:0] Q_OUT;
    logic                      SYM_STROBE;
    logic                      UNDERFLOW;

    modport master (
        output BIT_IN,
        output BIT_VALID,
        output SAMPLE_EN,
        input  BIT_READY,
        input  I_OUT,
        input  Q_OUT,
        input  SYM_STROBE,
        input  UNDERFLOW
    );

    modport slave (
        input  BIT_IN,
        input  BIT_VALID,
        input  SAMPLE_EN,
        output BIT_READY,
        output I_OUT,
        output Q_OUT,
        output SYM_STROBE,
        output UNDERFLOW
    );
endinterface

// File: rtl/qam16_symbol_upsampler.sv
// Packs serial bits into 16-QAM symbols, Gray-maps them to I/Q levels
// and zero-stuffs to SPS samples per symbol, paced by SAMPLE_EN.
module qam16_symbol_upsampler #(
    parameter int SPS     = 8,
    parameter int BIT_OUT = 14,
    parameter int AMP     = 2048
) (
    input logic                       CLOCK_50,
    input logic                       RESET,
    qam16_symbol_upsampler_if.slave   bus
);
    localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SPS - 1);
    localparam logic signed [BIT_OUT-1:0] L1 = BIT_OUT'(AMP);
    localparam logic signed [BIT_OUT-1:0] L3 = BIT_OUT'(3 * AMP);

    typedef enum logic {S_FILL, S_WAIT} state_t;

    state_t                    state;
    logic [3:0]                shreg;
    logic [1:0]                cnt;
    logic [3:0]                hold;
    logic                      hold_full;
    logic                      ready_r;
    logic [PW-1:0]             phase;
    logic signed [BIT_OUT-1:0] i_r;
    logic signed [BIT_OUT-1:0] q_r;
    logic                      sym_r;
    logic                      uf_r;

    logic       xfer;
    logic       consume;
    logic       hold_free;
    logic [3:0] nib;

    function automatic logic signed [BIT_OUT-1:0] lvl(input logic [1:0] b);
        logic signed [BIT_OUT-1:0] v;
        unique case (b)
            2'b00:   v = -L3;
            2'b01:   v = -L1;
            2'b11:   v = L1;
            default: v = L3;
        endcase
        return v;
    endfunction

    // Handshake and hold-register availability for this cycle
    always_comb begin
        xfer      = bus.BIT_VALID && ready_r;
        consume   = bus.SAMPLE_EN && (phase == '0) && hold_full;
        hold_free = !hold_full || consume;
        nib       = {shreg[2:0], bus.BIT_IN};
    end

    // Bit assembler FSM; a consumed hold may be refilled in the same cycle
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= S_FILL;
            shreg     <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            if (consume) hold_full <= 1'b0;
            unique case (state)
                S_FILL: begin
                    ready_r <= 1'b1;
                    if (xfer) begin
                        shreg <= nib;
                        cnt   <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (hold_free) begin
                                hold      <= nib;
                                hold_full <= 1'b1;
                            end else begin
                                state   <= S_WAIT;
                                ready_r <= 1'b0;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    ready_r <= 1'b0;
                    if (hold_free) begin
                        hold      <= shreg;
                        hold_full <= 1'b1;
                        state     <= S_FILL;
                        ready_r   <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Zero-stuffing upsampler; a missing symbol at phase 0 is lost
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            phase <= '0;
            i_r   <= '0;
            q_r   <= '0;
            sym_r <= 1'b0;
            uf_r  <= 1'b0;
        end else begin
            sym_r <= 1'b0;
            uf_r  <= 1'b0;
            if (bus.SAMPLE_EN) begin
                phase <= (phase == PMAX) ? '0 : phase + 1'b1;
                if (phase == '0 && hold_full) begin
                    i_r   <= lvl(hold[3:2]);
                    q_r   <= lvl(hold[1:0]);
                    sym_r <= 1'b1;
                end else begin
                    i_r  <= '0;
                    q_r  <= '0;
                    uf_r <= (phase == '0);
                end
            end
        end
    end

    assign bus.BIT_READY  = ready_r;
    assign bus.I_OUT      = i_r;
    assign bus.Q_OUT      = q_r;
    assign bus.SYM_STROBE = sym_r;
    assign bus.UNDERFLOW  = uf_r;
endmodule

// File: tb/tb_qam16_symbol_upsampler.sv
// Scoreboard bench for the 16-QAM symbol upsampler.
// Directed vectors; a monitor checks each registered sample.
module tb_qam16_symbol_upsampler;
    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;

    qam16_symbol_upsampler_if #(.BIT_OUT(14)) bus ();

    qam16_symbol_upsampler #(
        .SPS(8), .BIT_OUT(14), .AMP(2048)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int i;
        int q;
        int st;
        int uf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;
    logic se_q     = 1'b0;
    int   last_i   = 0;
    int   last_q   = 0;
    // Gray levels indexed by the 2-bit field: 00,01,10,11
    int   lv[4]    = '{-6144, -2048, 6144, 2048};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input int q, input int st, input int uf);
        exp_t e;
        e.i = i; e.q = q; e.st = st; e.uf = uf;
        sb.push_back(e);
    endtask

    task automatic sample(input int i, input int q, input int st,
                          input int uf, input int gap);
        push(i, q, st, uf);
        bus.SAMPLE_EN = 1'b1;
        @(negedge CLOCK_50);
        bus.SAMPLE_EN = 1'b0;
        repeat (gap) @(negedge CLOCK_50);
    endtask

    task automatic send_bits(input logic [63:0] bits, input int n);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 400) begin
            bus.BIT_VALID = 1'b1;
            bus.BIT_IN    = bits[n-1-idx];
            if (bus.BIT_READY) idx++;
            @(negedge CLOCK_50);
            guard++;
        end
        bus.BIT_VALID = 1'b0;
        if (idx < n) chk("bit_timeout", idx, n);
    endtask

    always @(posedge CLOCK_50) se_q <= bus.SAMPLE_EN && !RESET;

    // Monitor: pop on every sample, else outputs must hold and strobes idle
    always @(negedge CLOCK_50) begin
        if (RESET) begin
            last_i = 0;
            last_q = 0;
        end
        if (mon_en) begin
            if (se_q) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("i_out", int'(bus.I_OUT), e.i);
                    chk("q_out", int'(bus.Q_OUT), e.q);
                    chk("sym_strobe", int'(bus.SYM_STROBE), e.st);
                    chk("underflow", int'(bus.UNDERFLOW), e.uf);
                    last_i = e.i;
                    last_q = e.q;
                end
            end else begin
                chk("idle_strobe", int'(bus.SYM_STROBE), 0);
                chk("idle_uf", int'(bus.UNDERFLOW), 0);
                chk("hold_i", int'(bus.I_OUT), last_i);
                chk("hold_q", int'(bus.Q_OUT), last_q);
            end
        end
    end

    initial begin
        logic [63:0] all;
        int acc;
        bus.BIT_IN    = 1'b0;
        bus.BIT_VALID = 1'b0;
        bus.SAMPLE_EN = 1'b0;

        // reset
        repeat (2) @(negedge CLOCK_50);
        mon_en = 1'b1;
        chk("rst_ready", int'(bus.BIT_READY), 0);
        chk("rst_i", int'(bus.I_OUT), 0);
        chk("rst_q", int'(bus.Q_OUT), 0);
        RESET = 1'b0;
        @(negedge CLOCK_50);
        chk("ready_after_rst", int'(bus.BIT_READY), 1);

        // single symbol 1001
        send_bits(64'b1001, 4);
        sample(6144, -2048, 1, 0, 7);
        repeat (7) sample(0, 0, 0, 0, 7);

        // all 16 symbols with back-to-back sampling
        all = '0;
        for (int s = 0; s < 16; s++) all[63-4*s -: 4] = 4'(s);
        fork
            begin
                repeat (12) @(negedge CLOCK_50);
                for (int k = 0; k < 128; k++) begin
                    if (k % 8 == 0)
                        push(lv[(k/8)>>2], lv[(k/8)&3], 1, 0);
                    else
                        push(0, 0, 0, 0);
                    bus.SAMPLE_EN = 1'b1;
                    @(negedge CLOCK_50);
                end
                bus.SAMPLE_EN = 1'b0;
            end
            send_bits(all, 64);
        join
        @(negedge CLOCK_50);

        // starvation
        for (int k = 0; k < 24; k++)
            sample(0, 0, 0, (k % 8 == 0) ? 1 : 0, 1);

        // capacity: exactly 8 bits buffered
        acc = 0;
        bus.BIT_IN    = 1'b1;
        bus.BIT_VALID = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.BIT_READY) acc++;
            @(negedge CLOCK_50);
        end
        bus.BIT_VALID = 1'b0;
        chk("bits_accepted", acc, 8);
        chk("ready_stalled", int'(bus.BIT_READY), 0);
        sample(2048, 2048, 1, 0, 0);
        chk("ready_reraised", int'(bus.BIT_READY), 1);

        // reach phase 3 with assembler waiting, then reset
        sample(0, 0, 0, 0, 0);
        sample(0, 0, 0, 0, 0);
        send_bits(64'b0101, 4);
        chk("wait_full", int'(bus.BIT_READY), 0);
        RESET = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst2_i", int'(bus.I_OUT), 0);
        chk("rst2_q", int'(bus.Q_OUT), 0);
        RESET = 1'b0;
        @(negedge CLOCK_50);
        chk("rst2_ready", int'(bus.BIT_READY), 1);
        sample(0, 0, 0, 1, 3);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
